// File: rtl/io_timer_irq.sv
// Memory-mapped interval timer and frame counter for the 6502 bus, driving the CPU IRQ line.
// Everything runs on the pixel clock; read data is registered to match the one-cycle memory latency.
module io_timer_irq #(
    parameter logic [7:0] PRESCALE_RST = 8'd0,
    parameter int unsigned FRAME_W     = 16
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       frame,
    output logic       irq
);

    localparam logic [2:0] A_T1L    = 3'd0;
    localparam logic [2:0] A_T1H    = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_FRML   = 3'd4;
    localparam logic [2:0] A_FRMH   = 3'd5;
    localparam logic [2:0] A_PRESC  = 3'd6;

    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         latch_lo_q, latch_lo_d;
    logic [7:0]         latch_hi_q, latch_hi_d;
    logic               running_q, running_d;
    logic               t1_ie_q, t1_ie_d;
    logic               t1_cont_q, t1_cont_d;
    logic               frm_ie_q, frm_ie_d;
    logic               t1_flag_q, t1_flag_d;
    logic               frm_flag_q, frm_flag_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]         frm_hi_snap_q, frm_hi_snap_d;
    logic [7:0]         prescale_q, prescale_d;
    logic [7:0]         pcnt_q, pcnt_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               irq_q, irq_d;

    logic               wr_en, rd_en;
    logic               tick;
    logic               t1_set, t1_load, t1_clr, frm_clr;
    logic [15:0]        frame_ext;

    assign wr_en = cs & we;
    assign rd_en = cs & ~we;
    assign tick  = (pcnt_q == 8'd0);

    // Zero-extend so the register view always sees a 16-bit counter.
    always_comb begin
        frame_ext = '0;
        frame_ext[FRAME_W-1:0] = frame_cnt_q;
    end

    always_comb begin
        cnt_d         = cnt_q;
        latch_lo_d    = latch_lo_q;
        latch_hi_d    = latch_hi_q;
        running_d     = running_q;
        t1_ie_d       = t1_ie_q;
        t1_cont_d     = t1_cont_q;
        frm_ie_d      = frm_ie_q;
        prescale_d    = prescale_q;
        pcnt_d        = tick ? prescale_q : pcnt_q - 8'd1;
        t1_set        = 1'b0;
        t1_load       = 1'b0;
        t1_clr        = 1'b0;
        frm_clr       = 1'b0;

        if (tick && running_q) begin
            if (cnt_q == 16'd0) begin
                t1_set = 1'b1;
                if (t1_cont_q) begin
                    cnt_d = {latch_hi_q, latch_lo_q};
                end else begin
                    running_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end

        // Bus writes come after the timer update so a T1H load overrides a coincident tick.
        if (wr_en) begin
            case (reg_addr)
                A_T1L: latch_lo_d = wdata;
                A_T1H: begin
                    latch_hi_d = wdata;
                    cnt_d      = {wdata, latch_lo_q};
                    running_d  = 1'b1;
                    pcnt_d     = prescale_q;
                    t1_load    = 1'b1;
                end
                A_CTRL: begin
                    t1_ie_d   = wdata[0];
                    t1_cont_d = wdata[1];
                    frm_ie_d  = wdata[2];
                end
                A_STATUS: begin
                    t1_clr  = wdata[0];
                    frm_clr = wdata[1];
                end
                A_PRESC: prescale_d = wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        if (t1_load) begin
            t1_flag_d = 1'b0;
        end else if (t1_set) begin
            t1_flag_d = 1'b1;
        end else if (t1_clr) begin
            t1_flag_d = 1'b0;
        end else begin
            t1_flag_d = t1_flag_q;
        end

        if (frame) begin
            frm_flag_d = 1'b1;
        end else if (frm_clr) begin
            frm_flag_d = 1'b0;
        end else begin
            frm_flag_d = frm_flag_q;
        end

        frame_cnt_d = frame ? frame_cnt_q + 1'b1 : frame_cnt_q;

        // Built from next-state flags and enables so irq tracks the flags without extra lag.
        irq_d = (t1_flag_d & t1_ie_d) | (frm_flag_d & frm_ie_d);
    end

    always_comb begin
        rdata_d       = rdata_q;
        frm_hi_snap_d = frm_hi_snap_q;
        if (rd_en) begin
            case (reg_addr)
                A_T1L:    rdata_d = cnt_q[7:0];
                A_T1H:    rdata_d = cnt_q[15:8];
                A_CTRL:   rdata_d = {5'b0, frm_ie_q, t1_cont_q, t1_ie_q};
                A_STATUS: rdata_d = {irq_q, 5'b0, frm_flag_q, t1_flag_q};
                A_FRML: begin
                    rdata_d       = frame_ext[7:0];
                    frm_hi_snap_d = frame_ext[15:8];
                end
                A_FRMH:   rdata_d = frm_hi_snap_q;
                A_PRESC:  rdata_d = prescale_q;
                default:  rdata_d = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            cnt_q         <= '0;
            latch_lo_q    <= '0;
            latch_hi_q    <= '0;
            running_q     <= 1'b0;
            t1_ie_q       <= 1'b0;
            t1_cont_q     <= 1'b0;
            frm_ie_q      <= 1'b0;
            t1_flag_q     <= 1'b0;
            frm_flag_q    <= 1'b0;
            frame_cnt_q   <= '0;
            frm_hi_snap_q <= '0;
            prescale_q    <= PRESCALE_RST;
            pcnt_q        <= PRESCALE_RST;
            rdata_q       <= '0;
            irq_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            latch_lo_q    <= latch_lo_d;
            latch_hi_q    <= latch_hi_d;
            running_q     <= running_d;
            t1_ie_q       <= t1_ie_d;
            t1_cont_q     <= t1_cont_d;
            frm_ie_q      <= frm_ie_d;
            t1_flag_q     <= t1_flag_d;
            frm_flag_q    <= frm_flag_d;
            frame_cnt_q   <= frame_cnt_d;
            frm_hi_snap_q <= frm_hi_snap_d;
            prescale_q    <= prescale_d;
            pcnt_q        <= pcnt_d;
            rdata_q       <= rdata_d;
            irq_q         <= irq_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_io_timer_irq.sv
// Directed bench for io_timer_irq: a 16-bit frame counter instance and a 9-bit one share the bus.
// Expected read data is queued when a read is issued and compared when rdata becomes valid.
module tb_io_timer_irq;

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b1;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [2:0] reg_addr = 3'd0;
    logic [7:0] wdata = 8'd0;
    logic       frame = 1'b0;
    logic [7:0] rdata, rdata2;
    logic       irq, irq2;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [7:0] e1;
        logic [7:0] e2;
    } exp_t;
    exp_t sb[$];

    always #5 clk_pix = ~clk_pix;

    io_timer_irq #(.PRESCALE_RST(8'd0), .FRAME_W(16)) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .cs(cs), .we(we), .reg_addr(reg_addr),
        .wdata(wdata), .rdata(rdata), .frame(frame), .irq(irq)
    );

    io_timer_irq #(.PRESCALE_RST(8'd0), .FRAME_W(9)) dut9 (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .cs(cs), .we(we), .reg_addr(reg_addr),
        .wdata(wdata), .rdata(rdata2), .frame(frame), .irq(irq2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-12s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk_pix);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; reg_addr = a; wdata = d;
        edges(1);
        cs = 1'b0; we = 1'b0;
        $display("write addr %0d data %h", a, d);
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e1, input logic [7:0] e2,
                      input string tag);
        exp_t e;
        e.tag = tag; e.e1 = e1; e.e2 = e2;
        sb.push_back(e);
        cs = 1'b1; we = 1'b0; reg_addr = a;
        edges(1);
        cs = 1'b0;
        e = sb.pop_front();
        chk({e.tag, "_w16"}, rdata, e.e1);
        chk({e.tag, "_w9"}, rdata2, e.e2);
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1;
            edges(1);
            frame = 1'b0;
            edges(1);
        end
    endtask

    initial begin
        edges(2);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        rst_pix = 1'b0;
        edges(1);
        rd(3'd6, 8'h00, 8'h00, "rst_presc");

        // One-shot: latch 4, prescale 0 -> expiry 5 clocks after the T1H edge.
        wr(3'd6, 8'h00);
        wr(3'd2, 8'h01);
        wr(3'd0, 8'h04);
        wr(3'd1, 8'h00);
        edges(4);
        chk("os_irq_e4", {7'd0, irq}, 8'h00);
        edges(1);
        chk("os_irq_e5", {7'd0, irq}, 8'h01);
        rd(3'd3, 8'h81, 8'h81, "os_status");
        rd(3'd0, 8'h00, 8'h00, "os_cnt_lo");
        rd(3'd1, 8'h00, 8'h00, "os_cnt_hi");

        // Continuous: latch 2, prescale 3 -> expiry every 12 clocks.
        wr(3'd6, 8'h03);
        wr(3'd2, 8'h03);
        wr(3'd0, 8'h02);
        wr(3'd1, 8'h00);
        chk("ct_load_irq", {7'd0, irq}, 8'h00);
        edges(11);
        chk("ct_irq_e11", {7'd0, irq}, 8'h00);
        edges(1);
        chk("ct_irq_e12", {7'd0, irq}, 8'h01);
        edges(3);
        wr(3'd3, 8'h01);
        chk("ct_clr_irq", {7'd0, irq}, 8'h00);
        edges(7);
        chk("ct_irq_e23", {7'd0, irq}, 8'h00);
        edges(1);
        chk("ct_irq_e24", {7'd0, irq}, 8'h01);

        // Clear coinciding with expiry at E36: set wins.
        edges(11);
        wr(3'd3, 8'h01);
        chk("same_irq", {7'd0, irq}, 8'h01);
        rd(3'd3, 8'h81, 8'h81, "same_status");
        rd(3'd0, 8'h02, 8'h02, "reload_lo");

        // Stop continuous mode, let the last one-shot expire, then clear.
        wr(3'd2, 8'h00);
        edges(15);
        wr(3'd3, 8'h03);
        rd(3'd1, 8'h00, 8'h00, "stop_hi");
        rd(3'd0, 8'h00, 8'h00, "stop_lo");
        rd(3'd3, 8'h00, 8'h00, "stop_status");

        // Frame counter with snapshot across an intervening pulse.
        wr(3'd2, 8'h04);
        rd(3'd2, 8'h04, 8'h04, "ctrl_rd");
        pulse_frames(1);
        chk("frm_irq", {7'd0, irq}, 8'h01);
        chk("frm_irq_w9", {7'd0, irq2}, 8'h01);
        pulse_frames(299);
        rd(3'd4, 8'h2C, 8'h2C, "frml_300");
        pulse_frames(1);
        rd(3'd5, 8'h01, 8'h01, "frmh_snap");
        rd(3'd3, 8'h82, 8'h82, "frm_status");
        pulse_frames(211);
        rd(3'd4, 8'h00, 8'h00, "frml_512");
        rd(3'd5, 8'h02, 8'h00, "frmh_512");
        rd(3'd7, 8'h00, 8'h00, "addr7");

        // Reset mid-count with a write in flight.
        wr(3'd6, 8'h05);
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h01);
        rd(3'd1, 8'h01, 8'h01, "pre_rst_hi");
        chk("pre_rst_irq", {7'd0, irq}, 8'h01);
        cs = 1'b1; we = 1'b1; reg_addr = 3'd6; wdata = 8'h77;
        #3 rst_pix = 1'b1;
        #1;
        chk("async_rdata", rdata, 8'h00);
        chk("async_irq", {7'd0, irq}, 8'h00);
        edges(1);
        rst_pix = 1'b0; cs = 1'b0; we = 1'b0;
        edges(1);
        rd(3'd1, 8'h00, 8'h00, "post_hi");
        rd(3'd0, 8'h00, 8'h00, "post_lo");
        rd(3'd6, 8'h00, 8'h00, "post_presc");
        rd(3'd2, 8'h00, 8'h00, "post_ctrl");
        rd(3'd3, 8'h00, 8'h00, "post_status");
        rd(3'd4, 8'h00, 8'h00, "post_frml");
        rd(3'd5, 8'h00, 8'h00, "post_frmh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
